obstacle_spawn_scheduler: RTL and testbench

Schedules obstacle launches for the three obstacle slots of the runner game. Each frame it tracks the horizontal distance scrolled since the last launch and picks a randomised gap and obstacle type. When the gap is met it grants one free slot, round-robin. It also owns the scroll speed `dx`, which ramps with score. It sits between the game FSM, the score clock and the obstacle datapath, and replaces the fixed `dx` constant.

---
 rtl/obstacle_spawn_scheduler.sv | 170 +++++++++++++++++
 tb/tb_obstacle_spawn_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_spawn_scheduler
// Purpose  : Decides when and where the next obstacle is launched. Tracks the
//            horizontal distance scrolled since the last launch, picks a
//            randomised gap and obstacle type from an LFSR, grants one free
//            obstacle slot round-robin, and owns the score-driven scroll
//            speed dx.
// Ports    : clk         system clock, rising edge
//            rst         asynchronous active-low reset
//            frame_tick  one-cycle pulse per video frame
//            score_tick  one-cycle pulse per score increment
//            game_state  00 idle, 01 play, 10/11 dead
//            slot_free   bit i set: slot i may be reloaded
//            spawn_req   one-hot one-cycle load strobe
//            spawn_type  obstacle type, valid with spawn_req
//            spawn_x     load X coordinate (constant)
//            dx          scroll speed, pixels per frame
//            freeze      datapath must hold all positions
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_spawn_scheduler #(
    parameter int          SCREEN_W         = 640,
    parameter int          SPAWN_OFFSET     = 16,
    parameter int          MIN_GAP          = 200,
    parameter int          SPEED_INIT       = 5,
    parameter int          SPEED_MAX        = 12,
    parameter int          SPEED_STEP_TICKS = 100,
    parameter int          BIRD_SPEED       = 8,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        score_tick,
    input  logic [1:0]  game_state,
    input  logic [2:0]  slot_free,
    output logic [2:0]  spawn_req,
    output logic [1:0]  spawn_type,
    output logic [10:0] spawn_x,
    output logic [3:0]  dx,
    output logic        freeze
);

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] c_lfsrSeed = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_lfsr;
    logic [10:0] r_distance;
    logic [10:0] r_gapTarget;
    logic [1:0]  r_ptr;
    logic [7:0]  r_tickCnt;

    logic        w_feedback;
    logic        w_launch;
    logic [1:0]  w_order1;
    logic [1:0]  w_order2;
    logic [1:0]  w_grantIdx;
    logic [2:0]  w_grantOneHot;
    logic [1:0]  w_ptrNext;
    logic [1:0]  w_type;
    logic [11:0] w_distSum;
    logic [10:0] w_distNext;

    assign spawn_x = 11'(SCREEN_W + SPAWN_OFFSET);

    // Fibonacci taps 16, 14, 13, 11 (bit n-1), shifted in at the bottom.
    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (game_state == 2'b01) w_nextState = S_RUN;
            S_RUN: begin
                if (game_state == 2'b00)  w_nextState = S_IDLE;
                else if (game_state[1])   w_nextState = S_HALT;
            end
            S_HALT:  if (game_state == 2'b00) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Round-robin scan order: pointer, pointer+1, pointer+2 (mod 3).
    assign w_order1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    assign w_order2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;

    always_comb begin
        w_grantIdx = r_ptr;
        if (slot_free[r_ptr])         w_grantIdx = r_ptr;
        else if (slot_free[w_order1]) w_grantIdx = w_order1;
        else if (slot_free[w_order2]) w_grantIdx = w_order2;
    end

    assign w_grantOneHot = 3'b001 << w_grantIdx;
    assign w_ptrNext     = (w_grantIdx == 2'd2) ? 2'd0 : w_grantIdx + 2'd1;

    // The launch decision uses the registered state, so a frame tick that
    // coincides with RUN->HALT can still launch, and IDLE/HALT never do.
    assign w_launch = (r_state == S_RUN) && frame_tick &&
                      (r_distance >= r_gapTarget) && (slot_free != 3'b000);

    // Birds are only allowed once the scroll is fast enough.
    assign w_type = ((r_lfsr[9:8] == 2'b11) && (dx < 4'(BIRD_SPEED))) ? 2'b00 : r_lfsr[9:8];

    assign w_distSum  = {1'b0, r_distance} + {8'b0, dx};
    assign w_distNext = w_distSum[11] ? 11'h7FF : w_distSum[10:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= c_lfsrSeed;
            r_distance  <= 11'd0;
            r_gapTarget <= 11'(MIN_GAP);
            r_ptr       <= 2'd0;
            r_tickCnt   <= 8'd0;
            dx          <= 4'(SPEED_INIT);
            spawn_req   <= 3'b000;
            spawn_type  <= 2'b00;
            freeze      <= 1'b1;
        end else begin
            r_state    <= w_nextState;
            freeze     <= (w_nextState != S_RUN);
            r_lfsr     <= {r_lfsr[14:0], w_feedback};
            spawn_req  <= 3'b000;
            spawn_type <= 2'b00;
            case (r_state)
                S_RUN: begin
                    // A launching frame restarts the distance and drops its dx.
                    if (frame_tick) begin
                        r_distance <= w_launch ? 11'd0 : w_distNext;
                    end
                    if (w_launch) begin
                        spawn_req   <= w_grantOneHot;
                        spawn_type  <= w_type;
                        r_gapTarget <= 11'(MIN_GAP) + {4'b0, r_lfsr[6:0]};
                        r_ptr       <= w_ptrNext;
                    end
                    if (score_tick) begin
                        if (r_tickCnt == 8'(SPEED_STEP_TICKS - 1)) begin
                            r_tickCnt <= 8'd0;
                            if (dx < 4'(SPEED_MAX)) dx <= dx + 4'd1;
                        end else begin
                            r_tickCnt <= r_tickCnt + 8'd1;
                        end
                    end
                end
                S_HALT: begin
                    // Everything holds while the player is dead.
                end
                default: begin
                    r_distance  <= 11'd0;
                    r_gapTarget <= 11'(MIN_GAP);
                    r_ptr       <= 2'd0;
                    r_tickCnt   <= 8'd0;
                    dx          <= 4'(SPEED_INIT);
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_spawn_scheduler
// Purpose  : Self-checking bench for obstacle_spawn_scheduler. A cycle-level
//            reference model built from the game rules predicts every output;
//            a vector table and hand sequences cover the corner cases, and a
//            randomised run finishes the job.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_spawn_scheduler;

    localparam int          MIN_GAP    = 200;
    localparam int          SPEED_INIT = 5;
    localparam int          SPEED_MAX  = 12;
    localparam int          STEP_TICKS = 3;
    localparam int          BIRD_SPEED = 8;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ft  = 1'b0;
    logic        st  = 1'b0;
    logic [1:0]  gs  = 2'b00;
    logic [2:0]  sf  = 3'b111;
    logic [2:0]  spawn_req;
    logic [1:0]  spawn_type;
    logic [10:0] spawn_x;
    logic [3:0]  dx;
    logic        freeze;

    int nChecks = 0;
    int nErrors = 0;

    obstacle_spawn_scheduler #(
        .SCREEN_W(640), .SPAWN_OFFSET(16), .MIN_GAP(MIN_GAP),
        .SPEED_INIT(SPEED_INIT), .SPEED_MAX(SPEED_MAX),
        .SPEED_STEP_TICKS(STEP_TICKS), .BIRD_SPEED(BIRD_SPEED), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(ft), .score_tick(st),
        .game_state(gs), .slot_free(sf), .spawn_req(spawn_req),
        .spawn_type(spawn_type), .spawn_x(spawn_x), .dx(dx), .freeze(freeze)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          mState, mDist, mGap, mPtr, mCnt, mDx;
    logic [15:0] mLfsr;
    logic [2:0]  mReq;
    logic [1:0]  mType;
    logic        mFreeze;

    task automatic modelReset();
        mState = M_IDLE; mDist = 0; mGap = MIN_GAP; mPtr = 0; mCnt = 0;
        mDx = SPEED_INIT; mLfsr = SEED; mReq = 3'b000; mType = 2'b00; mFreeze = 1'b1;
    endtask

    task automatic modelEdge();
        bit launch;
        int g, t, nState;
        launch = (mState == M_RUN) && ft && (mDist >= mGap) && (sf != 3'b000);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (mPtr + k) % 3;
            if (g < 0 && sf[idx]) g = idx;
        end
        t = int'(mLfsr[9:8]);
        if (t == 3 && mDx < BIRD_SPEED) t = 0;
        mReq  = launch ? 3'(1 << g) : 3'b000;
        mType = launch ? 2'(t) : 2'b00;
        if (mState == M_IDLE) begin
            mDist = 0; mGap = MIN_GAP; mPtr = 0; mCnt = 0; mDx = SPEED_INIT;
        end else if (mState == M_RUN) begin
            if (ft) mDist = launch ? 0 : ((mDist + mDx > 2047) ? 2047 : mDist + mDx);
            if (launch) begin
                mGap = MIN_GAP + int'(mLfsr[6:0]);
                mPtr = (g + 1) % 3;
            end
            if (st) begin
                if (mCnt == STEP_TICKS - 1) begin
                    mCnt = 0;
                    mDx  = (mDx + 1 > SPEED_MAX) ? SPEED_MAX : mDx + 1;
                end else begin
                    mCnt = mCnt + 1;
                end
            end
        end
        nState = mState;
        if (mState == M_IDLE && gs == 2'b01) nState = M_RUN;
        else if (mState == M_RUN && gs == 2'b00) nState = M_IDLE;
        else if (mState == M_RUN && gs >= 2'b10) nState = M_HALT;
        else if (mState == M_HALT && gs == 2'b00) nState = M_IDLE;
        mState  = nState;
        mFreeze = (nState != M_RUN);
        mLfsr   = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) modelEdge();
        #1;
        check("spawn_req",  int'(spawn_req),  int'(mReq));
        check("spawn_type", int'(spawn_type), int'(mType));
        check("dx",         int'(dx),         mDx);
        check("freeze",     int'(freeze),     int'(mFreeze));
    endtask

    // Frame tick every 10 cycles until a strobe; returns tick count and grant.
    task automatic tickUntilReq(output int n, output logic [2:0] req);
        n = 0; req = 3'b000;
        for (int i = 0; i < 300 && req == 3'b000; i++) begin
            ft = 1'b1; step(); ft = 1'b0;
            n = i + 1;
            req = spawn_req;
            repeat (9) step();
        end
        check("tick_bound_reached", int'(req != 3'b000), 1);
    endtask

    typedef struct {
        logic [1:0] gs;
        logic       ft;
        logic       st;
        logic [2:0] expReq;
        logic [3:0] expDx;
        logic       expFreeze;
    } vec_t;

    vec_t        tbl[10];
    int          n;
    logic [2:0]  req;
    logic [2:0]  rrExp[3];
    int          guard;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // gs, ft, st -> req, dx, freeze (after the edge)
        tbl[0] = '{2'b00, 1'b0, 1'b0, 3'b000, 4'd5, 1'b1};
        tbl[1] = '{2'b01, 1'b0, 1'b0, 3'b000, 4'd5, 1'b0};
        tbl[2] = '{2'b01, 1'b1, 1'b1, 3'b000, 4'd5, 1'b0};
        tbl[3] = '{2'b01, 1'b0, 1'b1, 3'b000, 4'd5, 1'b0};
        tbl[4] = '{2'b01, 1'b0, 1'b1, 3'b000, 4'd6, 1'b0};
        tbl[5] = '{2'b10, 1'b0, 1'b1, 3'b000, 4'd6, 1'b1};
        tbl[6] = '{2'b10, 1'b1, 1'b1, 3'b000, 4'd6, 1'b1};
        tbl[7] = '{2'b00, 1'b0, 1'b0, 3'b000, 4'd6, 1'b1};
        tbl[8] = '{2'b00, 1'b0, 1'b0, 3'b000, 4'd5, 1'b1};
        tbl[9] = '{2'b00, 1'b1, 1'b0, 3'b000, 4'd5, 1'b1};

        // Reset state
        #2 rst = 1'b0;
        #1;
        modelReset();
        check("reset_spawn_req",  int'(spawn_req), 0);
        check("reset_spawn_type", int'(spawn_type), 0);
        check("reset_dx",         int'(dx), SPEED_INIT);
        check("reset_freeze",     int'(freeze), 1);
        check("spawn_x",          int'(spawn_x), 656);
        @(negedge clk) rst = 1'b1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            gs = tbl[i].gs; ft = tbl[i].ft; st = tbl[i].st;
            step();
            check("tbl_req",    int'(spawn_req), int'(tbl[i].expReq));
            check("tbl_dx",     int'(dx),        int'(tbl[i].expDx));
            check("tbl_freeze", int'(freeze),    int'(tbl[i].expFreeze));
        end
        ft = 1'b0; st = 1'b0;

        // First launch on the 41st tick at dx=5
        gs = 2'b01; sf = 3'b111; step();
        tickUntilReq(n, req);
        check("first_launch_tick", n, 41);
        check("first_launch_slot", int'(req), 1);
        check("gap_in_range", int'(mGap >= 200 && mGap <= 327), 1);

        // Round robin with all slots free
        rrExp[0] = 3'b010; rrExp[1] = 3'b100; rrExp[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tickUntilReq(n, req);
            check("rr_grant", int'(req), int'(rrExp[i]));
        end
        sf = 3'b101;
        tickUntilReq(n, req);
        check("rr_skip_busy", int'(req), 4);

        // Gap met with no free slot: hold off, then grant the first free tick
        sf = 3'b000; guard = 0;
        while (mDist < mGap && guard < 200) begin
            ft = 1'b1; step(); ft = 1'b0; step(); guard++;
        end
        check("gap_reach_bound", int'(guard < 200), 1);
        for (int i = 0; i < 5; i++) begin
            ft = 1'b1; step(); ft = 1'b0;
            check("no_slot_no_strobe", int'(spawn_req), 0);
            step();
        end
        sf = 3'b010;
        ft = 1'b1; step(); ft = 1'b0;
        check("late_grant", int'(spawn_req), 2);
        step();

        // Speed ramp
        for (int i = 1; i <= 21; i++) begin
            st = 1'b1; step(); st = 1'b0;
            if (i == 2) check("dx_before_step", int'(dx), 5);
            if (i == 3) check("dx_first_step", int'(dx), 6);
            step();
        end
        check("dx_saturated", int'(dx), 12);
        repeat (3) begin st = 1'b1; step(); st = 1'b0; step(); end
        check("dx_stays_max", int'(dx), 12);

        // Death mid-run with the gap already met
        sf = 3'b000; guard = 0;
        while (mDist < mGap && guard < 200) begin
            ft = 1'b1; step(); ft = 1'b0; step(); guard++;
        end
        gs = 2'b10; step();
        check("halt_freeze", int'(freeze), 1);
        sf = 3'b111;
        for (int i = 0; i < 3; i++) begin
            ft = 1'b1; st = 1'b1; step(); ft = 1'b0; st = 1'b0;
            check("halt_no_strobe", int'(spawn_req), 0);
            check("halt_dx_hold", int'(dx), 12);
            step();
        end
        gs = 2'b00; step(); step();
        check("idle_dx_restored", int'(dx), 5);

        // Asynchronous reset during a strobe
        gs = 2'b01; step();
        repeat (3) begin st = 1'b1; step(); st = 1'b0; step(); end
        guard = 0; req = 3'b000;
        while (req == 3'b000 && guard < 200) begin
            ft = 1'b1; step(); ft = 1'b0;
            req = spawn_req;
            if (req == 3'b000) begin step(); step(); end
            guard++;
        end
        check("strobe_before_reset", int'(req != 3'b000), 1);
        #2 rst = 1'b0;
        #1;
        modelReset();
        check("async_spawn_req",  int'(spawn_req), 0);
        check("async_spawn_type", int'(spawn_type), 0);
        check("async_dx",         int'(dx), SPEED_INIT);
        check("async_freeze",     int'(freeze), 1);
        @(negedge clk) rst = 1'b1;

        // Randomised run against the model
        for (int i = 0; i < 3000; i++) begin
            gs = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(0, 3)) : 2'b01;
            sf = 3'($urandom_range(0, 7));
            ft = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
